dram_responder: RTL

DRAM_RESPONDER -- requirements
Module: dram_responder

---
 rtl/dram_pkg.sv | 23 ++
 rtl/dram_responder_if.sv | 31 +++
 rtl/dram_mem_array.sv | 29 ++
 rtl/dram_responder.sv | 105 ++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types, response codes and address-map helpers for the DRAM responder.
package dram_pkg;
  typedef enum logic [2:0] {IDLE, RD_LAT, RD_RESP, WR_DATA, WR_LAT, WR_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 64;
  localparam int IDX_W   = 8;
  localparam int IDX_LSB = 3;
  localparam logic [ADDR_W-1:0] BASE_ADDR = 17'h10000;

  // Window is BASE_ADDR .. BASE_ADDR+2KiB, 8-byte aligned only.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[ADDR_W-1:IDX_LSB+IDX_W] == BASE_ADDR[ADDR_W-1:IDX_LSB+IDX_W]) &&
           (a[IDX_LSB-1:0] == '0);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[IDX_LSB +: IDX_W];
  endfunction
endpackage

// File: rtl/dram_responder_if.sv
// Read/write address, data and response channels between initiator and responder.
interface dram_responder_if;
  import dram_pkg::*;

  logic              AR_VALID;
  logic [ADDR_W-1:0] AR_ADDR;
  logic              AR_READY;
  logic              R_VALID;
  logic [DATA_W-1:0] R_DATA;
  logic [1:0]        R_RESP;
  logic              R_READY;
  logic              AW_VALID;
  logic [ADDR_W-1:0] AW_ADDR;
  logic              AW_READY;
  logic              W_VALID;
  logic [DATA_W-1:0] W_DATA;
  logic              W_READY;
  logic              B_VALID;
  logic [1:0]        B_RESP;
  logic              B_READY;

  modport slave (
    input  AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    output AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );

  modport master (
    output AR_VALID, AR_ADDR, R_READY, AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY,
    input  AR_READY, R_VALID, R_DATA, R_RESP, AW_READY, W_READY, B_VALID, B_RESP
  );
endinterface

// File: rtl/dram_mem_array.sv
// DEPTH x 64 storage with one write port and one registered read port, cleared by reset.
module dram_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_idx,
  input  logic [63:0]   wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_idx,
  output logic [63:0]   rd_data
);
  logic [63:0] mem [DEPTH];
  logic [63:0] rd_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data_reg <= '0;
    end else begin
      if (we) mem[wr_idx] <= wr_data;
      if (re) rd_data_reg <= mem[rd_idx];
    end
  end

  assign rd_data = rd_data_reg;
endmodule

// File: rtl/dram_responder.sv
// Single-outstanding DRAM responder: one read or write in flight, fixed LAT-cycle response delay.
module dram_responder
  import dram_pkg::*;
#(
  parameter int LAT   = 4,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  dram_responder_if.slave  bus
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             err_reg, err_next;
  logic             mem_we, mem_re;
  logic [63:0]      rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.AR_VALID) begin
          state_next = RD_LAT;
          cnt_next   = CNT_INIT;
          idx_next   = addr_idx(bus.AR_ADDR);
          err_next   = !addr_ok(bus.AR_ADDR);
        end else if (bus.AW_VALID) begin
          state_next = WR_DATA;
          idx_next   = addr_idx(bus.AW_ADDR);
          err_next   = !addr_ok(bus.AW_ADDR);
        end
      end
      RD_LAT: begin
        // Array read is issued on the last latency edge so data lands with R_VALID.
        if (cnt_reg == 4'd0) begin
          state_next = RD_RESP;
          mem_re     = !err_reg;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RD_RESP: begin
        if (bus.R_READY) state_next = IDLE;
      end
      WR_DATA: begin
        if (bus.W_VALID) begin
          state_next = WR_LAT;
          cnt_next   = CNT_INIT;
          mem_we     = !err_reg;
        end
      end
      WR_LAT: begin
        if (cnt_reg == 4'd0) state_next = WR_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      WR_RESP: begin
        if (bus.B_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  dram_mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (mem_we),
    .wr_idx  (idx_reg[AW-1:0]),
    .wr_data (bus.W_DATA),
    .re      (mem_re),
    .rd_idx  (idx_reg[AW-1:0]),
    .rd_data (rd_data)
  );

  assign bus.AR_READY = (state_reg == IDLE);
  assign bus.AW_READY = (state_reg == IDLE) && !bus.AR_VALID;
  assign bus.W_READY  = (state_reg == WR_DATA);
  assign bus.R_VALID  = (state_reg == RD_RESP);
  assign bus.R_DATA   = (state_reg == RD_RESP && !err_reg) ? rd_data : '0;
  assign bus.R_RESP   = (state_reg == RD_RESP && err_reg) ? RESP_SLVERR : RESP_OKAY;
  assign bus.B_VALID  = (state_reg == WR_RESP);
  assign bus.B_RESP   = (state_reg == WR_RESP && err_reg) ? RESP_SLVERR : RESP_OKAY;
endmodule
